// File: rtl/fib_stream_checker_pkg.sv
// ----------------------------------------------------------------------------
// fib_stream_checker_pkg
//   Shared definitions for the Fibonacci stream checker slice: checker FSM
//   state encoding and the default data / counter widths.
//   No ports (package).
// ----------------------------------------------------------------------------
package fib_stream_checker_pkg;

    // Default widths; the sample width must track the upstream adder.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Checker FSM states. The encoding is fixed so that log dumps and
    // debug probes from older harness scripts still decode correctly.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/fib_stream_checker_if.sv
// ----------------------------------------------------------------------------
// fib_stream_checker_if
//   Groups the sample stream and the log read bus of the checker.
//   Signals:
//     in_valid  sample strobe          (master -> slave)
//     in_data   sample value           (master -> slave)
//     in_cout   upstream carry-out     (master -> slave)
//     rd_en     log read strobe        (master -> slave)
//     rd_addr   log read address       (master -> slave)
//     rd_data   registered read data   (slave -> master)
//   Modports: master = producer / harness side, slave = checker side.
// ----------------------------------------------------------------------------
interface fib_stream_checker_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_cout;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output in_valid, in_data, in_cout, rd_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  in_valid, in_data, in_cout, rd_en, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/fib_stream_checker_log_ram.sv
// ----------------------------------------------------------------------------
// fib_log_ram
//   DEPTH x DATA_W sample log. One write port, one registered read port.
//   A read and write to the same address in one cycle returns the old data.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   async active-high reset (read register only)
//     wr_en    in   write strobe
//     wr_addr  in   write address
//     wr_data  in   write data
//     rd_en    in   read strobe; rd_data holds when low
//     rd_addr  in   read address
//     rd_data  out  registered read data
// ----------------------------------------------------------------------------
module fib_log_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read. Sampling mem with a non-blocking read on the same
    // edge as a write gives the pre-write contents on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fib_stream_checker.sv
// ----------------------------------------------------------------------------
// fib_stream_checker
//   Consumes the Fibonacci generator output and checks each sample against
//   a[n] = a[n-1] + a[n-2] mod 2^DATA_W. Counts matches, mismatches and
//   carry-out events, halts after ERR_LIMIT mismatches, and logs every
//   accepted sample into a circular RAM readable by the test harness.
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   async active-high reset
//     bus          slave modport: in_valid/in_data/in_cout, rd_en/rd_addr/rd_data
//     clear        in   sync clear of counters, flags, pointer and FSM
//     match_count  out  recurrence checks passed (saturating)
//     err_count    out  recurrence checks failed (saturating)
//     carry_count  out  checked samples with in_cout=1 (saturating)
//     err_flag     out  sticky, first mismatch
//     wrapped      out  sticky, write pointer wrapped
//     halted       out  high while in S_HALT
// ----------------------------------------------------------------------------
module fib_stream_checker
    import fib_stream_checker_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int ERR_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fib_stream_checker_if.slave  bus,
    input  logic                 clear,
    output logic [CNT_W-1:0]     match_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     carry_count,
    output logic                 err_flag,
    output logic                 wrapped,
    output logic                 halted
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(ERR_LIMIT);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [DATA_W-1:0] prev1;
    logic [DATA_W-1:0] prev2;
    logic [ADDR_W-1:0] wr_ptr;

    logic              accept;
    logic              log_we;
    logic [DATA_W-1:0] exp_sum;
    logic              is_match;
    logic [CNT_W-1:0]  err_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Sample acceptance and the comparison datapath. The sum is truncated
    // to DATA_W so the check follows the upstream adder's wraparound.
    always_comb begin
        accept   = bus.in_valid && (state != S_HALT);
        log_we   = accept && !clear;
        exp_sum  = prev1 + prev2;
        is_match = (bus.in_data == exp_sum);
        err_inc  = sat_inc(err_count);
    end

    // Checker FSM plus counters and write pointer. clear wins over a sample
    // arriving in the same cycle, so that sample is neither logged nor
    // checked. After every check the history resyncs to the actual data,
    // which is why one corrupted sample shows up as three mismatches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            prev1       <= '0;
            prev2       <= '0;
            wr_ptr      <= '0;
            match_count <= '0;
            err_count   <= '0;
            carry_count <= '0;
            err_flag    <= 1'b0;
            wrapped     <= 1'b0;
            halted      <= 1'b0;
        end else if (clear) begin
            state       <= S_IDLE;
            prev1       <= '0;
            prev2       <= '0;
            wr_ptr      <= '0;
            match_count <= '0;
            err_count   <= '0;
            carry_count <= '0;
            err_flag    <= 1'b0;
            wrapped     <= 1'b0;
            halted      <= 1'b0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (wr_ptr == PTR_LAST) begin
                wrapped <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    prev2 <= bus.in_data;
                    state <= S_PRIME;
                end
                S_PRIME: begin
                    prev1 <= bus.in_data;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (is_match) begin
                        match_count <= sat_inc(match_count);
                    end else begin
                        err_count <= err_inc;
                        err_flag  <= 1'b1;
                        if (err_inc >= LIMIT) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    end
                    if (bus.in_cout) begin
                        carry_count <= sat_inc(carry_count);
                    end
                    prev2 <= prev1;
                    prev1 <= bus.in_data;
                end
                default: begin
                end
            endcase
        end
    end

    fib_log_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_log (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (log_we),
        .wr_addr (wr_ptr),
        .wr_data (bus.in_data),
        .rd_en   (bus.rd_en),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

endmodule

// File: tb/tb_fib_stream_checker.sv
// ----------------------------------------------------------------------------
// tb_fib_stream_checker
//   Directed self-checking bench for fib_stream_checker: clean sequence,
//   8-bit wraparound with carry, single corrupted sample, error-limit halt,
//   clear priority, log wrap with read/write collision, async reset mid-run.
// ----------------------------------------------------------------------------
module tb_fib_stream_checker;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [15:0] match_count;
    logic [15:0] err_count;
    logic [15:0] carry_count;
    logic        err_flag;
    logic        wrapped;
    logic        halted;

    int assertCount = 0;
    int failCount   = 0;

    // Fibonacci mod 256 starting 1,1 (hand computed: 144+233=377->121,
    // 233+121=354->98, 121+98=219, 98+219=317->61).
    logic [7:0] seq [17] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
                             8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121,
                             8'd98, 8'd219, 8'd61};

    fib_stream_checker_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    fib_stream_checker #(
        .DATA_W    (8),
        .DEPTH     (16),
        .ADDR_W    (4),
        .CNT_W     (16),
        .ERR_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear       (clear),
        .match_count (match_count),
        .err_count   (err_count),
        .carry_count (carry_count),
        .err_flag    (err_flag),
        .wrapped     (wrapped),
        .halted      (halted)
    );

    // 10 ns clock; DUT acts on posedge, bench drives and samples on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counted, then checked with an immediate assertion.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One valid sample for one cycle, called at a negedge.
    task automatic applyStimulus(input logic [7:0] data, input logic cout);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_cout  = cout;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_cout  = 1'b0;
    endtask

    task automatic readLog(input logic [3:0] addr, input logic [7:0] exp,
                           input string tag);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        @(negedge clk);
        bus.rd_en   = 1'b0;
        checkOutput(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_match"},   32'(match_count), 32'd0);
        checkOutput({tag, "_err"},     32'(err_count),   32'd0);
        checkOutput({tag, "_carry"},   32'(carry_count), 32'd0);
        checkOutput({tag, "_errflag"}, 32'(err_flag),    32'd0);
        checkOutput({tag, "_wrapped"}, 32'(wrapped),     32'd0);
        checkOutput({tag, "_halted"},  32'(halted),      32'd0);
        checkOutput({tag, "_rddata"},  32'(bus.rd_data), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_cout  = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Clean sequence 1,1,2,3,5,8,13: five checks, all matching.
        $display("[TB] clean sequence");
        for (int i = 0; i < 7; i++) applyStimulus(seq[i], 1'b0);
        checkOutput("t1_match", 32'(match_count), 32'd5);
        checkOutput("t1_err", 32'(err_count), 32'd0);
        checkOutput("t1_errflag", 32'(err_flag), 32'd0);
        for (int i = 0; i < 7; i++) readLog(4'(i), seq[i], "t1_log");

        // Continue through the 8-bit wrap; 121 arrives with carry-out.
        $display("[TB] wraparound with carry");
        for (int i = 7; i < 14; i++) applyStimulus(seq[i], (i == 13));
        checkOutput("t2_match", 32'(match_count), 32'd12);
        checkOutput("t2_carry", 32'(carry_count), 32'd1);
        checkOutput("t2_err", 32'(err_count), 32'd0);
        pulseClear();
        checkOutput("clr_match", 32'(match_count), 32'd0);
        checkOutput("clr_carry", 32'(carry_count), 32'd0);

        // One corrupted sample (9 instead of 5) -> mismatches on 9, 8, 13.
        $display("[TB] single corrupted sample");
        applyStimulus(8'd1, 1'b0);
        applyStimulus(8'd1, 1'b0);
        applyStimulus(8'd2, 1'b0);
        applyStimulus(8'd3, 1'b0);
        applyStimulus(8'd9, 1'b0);
        applyStimulus(8'd8, 1'b0);
        applyStimulus(8'd13, 1'b0);
        applyStimulus(8'd21, 1'b0);
        checkOutput("t3_err", 32'(err_count), 32'd3);
        checkOutput("t3_match", 32'(match_count), 32'd3);
        checkOutput("t3_errflag", 32'(err_flag), 32'd1);
        checkOutput("t3_halted", 32'(halted), 32'd0);

        // Clear together with a valid sample: the sample must be dropped,
        // so the following 1,1 primes cleanly from address 0.
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(negedge clk);
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("clr_errflag", 32'(err_flag), 32'd0);
        checkOutput("clr_err", 32'(err_count), 32'd0);

        // Prime 1,1 then four bad samples -> err_count reaches 4 and halts.
        $display("[TB] error limit halt");
        applyStimulus(8'd1, 1'b0);
        applyStimulus(8'd1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(8'd5, 1'b1);
        checkOutput("t4_err", 32'(err_count), 32'd4);
        checkOutput("t4_halted", 32'(halted), 32'd1);
        checkOutput("t4_carry", 32'(carry_count), 32'd4);
        readLog(4'd0, 8'd1, "t4_log0");
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        checkOutput("t4_err_held", 32'(err_count), 32'd4);
        checkOutput("t4_match_held", 32'(match_count), 32'd0);
        checkOutput("t4_carry_held", 32'(carry_count), 32'd4);
        checkOutput("t4_halted_held", 32'(halted), 32'd1);
        // Addresses 6 and 7 still hold 13 and 21 from the previous run.
        readLog(4'd6, 8'd13, "t4_log6");
        readLog(4'd7, 8'd21, "t4_log7");
        pulseClear();
        checkOutput("t4_clr_halted", 32'(halted), 32'd0);
        checkOutput("t4_clr_err", 32'(err_count), 32'd0);

        // Seventeen samples: wrap after the 16th, collide read on the 17th.
        $display("[TB] log wrap and collision");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(seq[i], 1'b0);
            if (i == 14) checkOutput("t5_wrapped_pre", 32'(wrapped), 32'd0);
        end
        checkOutput("t5_wrapped", 32'(wrapped), 32'd1);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd0;
        applyStimulus(seq[16], 1'b0);
        bus.rd_en   = 1'b0;
        checkOutput("t5_collide_old", 32'(bus.rd_data), 32'd1);
        readLog(4'd0, 8'd61, "t5_log0_new");
        readLog(4'd15, 8'd219, "t5_log15");
        checkOutput("t5_match", 32'(match_count), 32'd15);
        checkOutput("t5_err", 32'(err_count), 32'd0);

        // Async reset while in S_CHECK: outputs clear without a clock edge.
        $display("[TB] async reset mid-stream");
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'd5, 1'b0);
        applyStimulus(8'd7, 1'b0);
        applyStimulus(8'd12, 1'b0);
        checkOutput("t6_match", 32'(match_count), 32'd1);
        checkOutput("t6_err", 32'(err_count), 32'd0);
        checkOutput("t6_errflag", 32'(err_flag), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
